// File: rtl/eth_pkg.sv
// eth_pkg -- shared definitions for the MII receive path.
//   rx_state_e   : deframer state encoding (IDLE, PREAMBLE, RECV, DROP)
//   PREAMBLE_NIB : preamble nibble value (4'h5)
//   SFD_NIB      : start-of-frame-delimiter high nibble (4'hD)
//   CRC_POLY     : Ethernet CRC-32 polynomial, normal (MSB-first) form
//   CRC_RESIDUE  : good-frame residue, normal form
//   CRC_INIT     : CRC register preset
//   reflect32()  : bit-reverse helper, used to derive the LSB-first constants
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_RECV,
    ST_DROP
  } rx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte -- combinational one-byte update of the Ethernet CRC-32.
// The register is kept in reflected (LSB-first) form because Ethernet sends
// each byte least-significant bit first.
//   crc_in  [31:0] : current CRC register
//   data_in [7:0]  : byte to absorb
//   crc_out [31:0] : CRC register after absorbing data_in
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_work = (crc_work[0] ^ data_in[i]) ? ((crc_work >> 1) ^ POLY_REFL)
                                            : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer -- strips preamble/SFD from an MII nibble stream and emits
// frame bytes with end-of-frame status.
//   clk            : MII receive clock, all logic on the rising edge
//   reset          : synchronous, active-low
//   phy_rx_dv      : receive data valid
//   phy_rxd[3:0]   : receive nibble, low nibble of each byte first
//   rx_mac_data    : frame byte (SFD stripped)
//   rx_mac_valid   : rx_mac_data valid this cycle
//   rx_mac_last    : final byte of the frame
//   rx_stat_valid  : status strobe, coincident with rx_mac_last
//   rx_frame_len   : frame byte count, valid with rx_stat_valid
//   rx_err         : alignment / oversize (/ CRC) error, valid with rx_stat_valid
// Build option: define MII_RX_CRC_CHECK_EN to add the CRC-32 residue check.
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phy_rx_dv,
  input  logic [3:0]  phy_rxd,
  output logic [7:0]  rx_mac_data,
  output logic        rx_mac_valid,
  output logic        rx_mac_last,
  output logic        rx_stat_valid,
  output logic [15:0] rx_frame_len,
  output logic        rx_err
);

  rx_state_e   state_q, state_d;
  logic        dv_prev_q;
  logic        nib_phase_q, nib_phase_d;   // 1: low nibble captured, waiting for high
  logic [3:0]  low_nib_q, low_nib_d;
  logic [7:0]  held_q, held_d;             // one-deep byte buffer
  logic        held_vld_q, held_vld_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flush_q, flush_d;           // final byte waiting to go out with last
  logic        flush_err_q, flush_err_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        stat_q, stat_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;

  logic [7:0]  byte_w;
  logic [15:0] cnt_inc;
  logic        crc_bad;

  assign byte_w  = {phy_rxd, low_nib_q};
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data_in (byte_w),
    .crc_out (crc_next)
  );

  // The register is LSB-first, so the good-frame residue is compared reflected.
  assign crc_bad = (crc_q != reflect32(CRC_RESIDUE));
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    nib_phase_d = nib_phase_q;
    low_nib_d   = low_nib_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    flush_err_d = flush_err_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    stat_d      = 1'b0;
    len_d       = len_q;
    err_d       = err_q;
`ifdef MII_RX_CRC_CHECK_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A frame may only start after dv has been seen low; this keeps a
        // frame interrupted by reset from being picked up mid-stream.
        if (phy_rx_dv) begin
          state_d = (phy_rxd == PREAMBLE_NIB && !dv_prev_q) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_d = ST_IDLE;
        end else if (phy_rxd == SFD_NIB) begin
          state_d     = ST_RECV;
          cnt_d       = 16'd0;
          nib_phase_d = 1'b0;
          held_vld_d  = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
          crc_d       = CRC_INIT;
`endif
        end else if (phy_rxd != PREAMBLE_NIB) begin
          state_d = ST_DROP;
        end
      end
      ST_RECV: begin
        if (!phy_rx_dv) begin
          state_d     = ST_IDLE;
          nib_phase_d = 1'b0;
          held_vld_d  = 1'b0;
          if (held_vld_q) begin
            flush_d     = 1'b1;
            flush_err_d = nib_phase_q | crc_bad;
          end
        end else if (!nib_phase_q) begin
          low_nib_d   = phy_rxd;
          nib_phase_d = 1'b1;
        end else begin
          nib_phase_d = 1'b0;
          cnt_d       = cnt_inc;
`ifdef MII_RX_CRC_CHECK_EN
          crc_d       = crc_next;
`endif
          if (held_vld_q) begin
            valid_d = 1'b1;
            data_d  = held_q;
          end
          held_d     = byte_w;
          held_vld_d = 1'b1;
          if (int'(cnt_inc) == MAX_FRAME_LEN) begin
            held_vld_d  = 1'b0;
            flush_d     = 1'b1;
            flush_err_d = 1'b1;
            state_d     = ST_DROP;
          end
        end
      end
      default: begin // ST_DROP
        if (!phy_rx_dv && !flush_q) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // The final byte waits for a free cycle so valid never runs back-to-back.
    if (flush_q && !valid_q) begin
      flush_d = 1'b0;
      valid_d = 1'b1;
      last_d  = 1'b1;
      stat_d  = 1'b1;
      data_d  = held_q;
      len_d   = cnt_q;
      err_d   = flush_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dv_prev_q   <= 1'b1;
      nib_phase_q <= 1'b0;
      low_nib_q   <= 4'h0;
      held_q      <= 8'h00;
      held_vld_q  <= 1'b0;
      cnt_q       <= 16'd0;
      flush_q     <= 1'b0;
      flush_err_q <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      stat_q      <= 1'b0;
      len_q       <= 16'd0;
      err_q       <= 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q       <= CRC_INIT;
`endif
    end else begin
      state_q     <= state_d;
      dv_prev_q   <= phy_rx_dv;
      nib_phase_q <= nib_phase_d;
      low_nib_q   <= low_nib_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      flush_err_q <= flush_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      stat_q      <= stat_d;
      len_q       <= len_d;
      err_q       <= err_d;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign rx_mac_data   = data_q;
  assign rx_mac_valid  = valid_q;
  assign rx_mac_last   = last_q;
  assign rx_stat_valid = stat_q;
  assign rx_frame_len  = len_q;
  assign rx_err        = err_q;

endmodule
